// File: rtl/mdu_hilo_pkg.sv
// Shared op codes, FSM encodings and op-decode helpers for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Long ops hold busy for 33 cycles; MTHI/MTLO write in one cycle; start while busy is ignored.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign sgn_a = is_signed_op(op) & a[WIDTH-1];
  assign sgn_b = is_signed_op(op) & b[WIDTH-1];
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;

  // Multiply: acc = {partial_product, remaining multiplier bits}, opnd = multiplicand.
  // Divide:   acc = {partial_remainder, dividend/quotient bits},  opnd = divisor.
  logic [WIDTH:0]     lhs;
  logic [WIDTH+1:0]   addend;
  logic [WIDTH+1:0]   sum;
  logic               fits;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    lhs     = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    addend  = is_div ? ~{2'b00, opnd} : {2'b00, opnd};
    sum     = {1'b0, lhs} + addend + {{(WIDTH+1){1'b0}}, is_div};
    fits    = ~sum[WIDTH+1];
    acc_nxt = acc;
    if (is_div)
      acc_nxt = {(fits ? sum[WIDTH-1:0] : lhs[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    else if (acc[0])
      acc_nxt = {sum[WIDTH:0], acc[WIDTH-1:1]};
    else
      acc_nxt = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = neg_rem ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_long_op(op)) begin
              state    <= ST_CALC;
              cnt      <= '0;
              busy     <= 1'b1;
              is_div   <= is_div_op(op);
              neg_res  <= sgn_a ^ sgn_b;
              neg_rem  <= sgn_a;
              div_zero <= (b == '0);
              acc      <= {{WIDTH{1'b0}}, (is_div_op(op) ? mag_a : mag_b)};
              opnd     <= is_div_op(op) ? mag_b : mag_a;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST)
            state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div) begin
            // Zero divisor leaves the dividend magnitude as remainder, so rem_fix equals a.
            lo <= div_zero ? {WIDTH{1'b1}} : quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
